// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame
// parameters used by the transmitter and its parent.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned UART_DBIT    = 8;
  localparam int unsigned UART_OS      = 16;
  localparam int unsigned UART_SB_TICK = 16;

endpackage

// File: rtl/uart_tx_oversampled.sv
// Oversampled UART transmitter.
// Shifts a parallel word out as start bit, DBIT data bits (LSB first),
// an optional even-parity bit and a stop period of SB_TICK ticks. Every
// start/data/parity bit lasts OS ticks of s_tick (the mod-M counter pulse).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   s_tick       one-cycle tick at OS x baud
//   tx_start     send request, honoured only while tx_ready is high
//   din          data word, captured on the accepting cycle
//   tx_ready     high while idle
//   tx_done_tick one-cycle pulse at the end of the stop period
//   tx           registered serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to insert the even-parity bit.
module uart_tx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = UART_DBIT,
  parameter int unsigned OS      = UART_OS,
  parameter int unsigned SB_TICK = UART_SB_TICK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int unsigned SW = $clog2(2 * OS);
  localparam int unsigned NW = $clog2(DBIT);
  localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        // A tick coinciding with the accept is deliberately not counted.
        if (tx_start) begin
          b_d     = din;
          s_cnt_d = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == OS_LAST) begin
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            s_cnt_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so tx changes on the same
    // edge as the state register, keeping the output registered.
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_ready     = (state_q == IDLE);
  assign tx_done_tick = done_q;
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_oversampled.sv
module tb_uart_tx_oversampled;
  import uart_pkg::*;

  localparam int unsigned DBIT = UART_DBIT;
  localparam int unsigned OS   = UART_OS;
  localparam int unsigned SBT  = UART_SB_TICK;
  localparam int unsigned SBT2 = 32;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NBITS = 1 + DBIT + P;
  localparam int unsigned FRAME = NBITS * OS + SBT;

  logic clk = 1'b0;
  logic rst, s_tick, tx_start, tx_ready, tx_done_tick, tx;
  logic [DBIT-1:0] din;
  logic tick_hi = 1'b1;
  logic tx_start2, tx_ready2, tx_done2, tx2;
  logic [DBIT-1:0] din2;

  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    logic [DBIT-1:0] data;
    bit              b2b;
  } exp_t;
  exp_t exp_q[$];

  int unsigned tick_total = 0;
  int unsigned cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned mon_rel = 0;
  bit          busy = 0;

  always #5 clk = ~clk;

  uart_tx_oversampled #(.DBIT(DBIT), .OS(OS), .SB_TICK(SBT)) u_dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx(tx)
  );

  uart_tx_oversampled #(.DBIT(DBIT), .OS(OS), .SB_TICK(SBT2)) u_dut_cont (
    .clk(clk), .rst(rst), .s_tick(tick_hi), .tx_start(tx_start2), .din(din2),
    .tx_ready(tx_ready2), .tx_done_tick(tx_done2), .tx(tx2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [DBIT-1:0] d, input int unsigned b);
    if (b == 0) return 1'b0;
    if (b <= DBIT) return d[b-1];
    return ^d;
  endfunction

  // Tick every 4th clock for the main instance.
  initial begin
    int unsigned div = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == 3) ? 0 : div + 1;
      s_tick = (div == 3);
    end
  end

  always @(posedge clk) if (s_tick) tick_total++;

  // Frame monitor: decodes the line by tick position and pops the scoreboard.
  initial begin
    exp_t        cur;
    int unsigned nb = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 0;
        exp_q.delete();
        continue;
      end
      if (!busy) begin
        check_eq("idle_done", tx_done_tick, 1'b0);
        if (tx === 1'b0) begin
          check_eq("start_ready_low", tx_ready, 1'b0);
          check_eq("frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            if (cur.b2b) check_eq("b2b_gap", cyc - done_cyc, 1);
            busy    = 1;
            nb      = 0;
            mon_rel = 0;
            tick_total = 0;
          end
        end else begin
          check_eq("idle_ready", tx_ready, 1'b1);
        end
      end else begin
        mon_rel = tick_total;
        if (nb < NBITS && mon_rel == nb * OS + OS / 2) begin
          check_eq($sformatf("bit%0d_d%0h", nb, cur.data), tx, exp_bit(cur.data, nb));
          nb++;
        end else if (nb == NBITS && mon_rel == NBITS * OS + SBT / 2) begin
          check_eq("stop_level", tx, 1'b1);
          nb++;
        end
        if (tx_done_tick) begin
          check_eq("frame_ticks", mon_rel, FRAME);
          check_eq("bits_seen", nb, NBITS + 1);
          busy     = 0;
          done_cyc = cyc;
        end else if (mon_rel > FRAME) begin
          check_eq("done_timeout", mon_rel, FRAME);
          busy = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DBIT-1:0] d);
    int unsigned n = 0;
    @(negedge clk);
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready_wait", n < 3000, 1'b1);
    din      = d;
    tx_start = 1'b1;
    exp_q.push_back('{data: d, b2b: 1'b0});
    @(negedge clk);
    tx_start = 1'b0;
    din      = DBIT'($urandom);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_wait", n < 3000, 1'b1);
  endtask

  task automatic wait_ready(input logic lvl);
    int unsigned n = 0;
    while (tx_ready !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", n < 3000, 1'b1);
  endtask

  initial begin
    int unsigned n, rise;
    logic prev;
    rst = 1'b1; tx_start = 1'b0; din = '0; tx_start2 = 1'b0; din2 = '0;

    // Reset held three cycles.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_ready", tx_ready, 1'b1);
      check_eq("rst_done", tx_done_tick, 1'b0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_tx", tx, 1'b1);

    send(8'hA5); wait_idle();
    send(8'h07); wait_idle();
    send(8'h3C); wait_idle();

    // Back-to-back with tx_start held high throughout.
    @(negedge clk);
    din = 8'h00; tx_start = 1'b1;
    exp_q.push_back('{data: 8'h00, b2b: 1'b0});
    @(negedge clk);
    wait_ready(1'b0);
    din = 8'hFF;
    exp_q.push_back('{data: 8'hFF, b2b: 1'b1});
    wait_ready(1'b1);
    @(negedge clk);
    wait_ready(1'b0);
    tx_start = 1'b0;
    wait_idle();

    // Abort during data bit 3.
    send(8'hC3);
    n = 0;
    while (!(busy && mon_rel >= 4 * OS + 4) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reach", n < 2000, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_tx", tx, 1'b1);
    check_eq("abort_ready", tx_ready, 1'b1);
    check_eq("abort_done", tx_done_tick, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    send(8'h3C); wait_idle();

    // Continuous tick instance with a two-bit stop period.
    @(negedge clk);
    din2 = 8'h5A; tx_start2 = 1'b1;
    @(negedge clk);
    tx_start2 = 1'b0;
    din2 = 8'hFF;
    check_eq("cont_start_tx", tx2, 1'b0);
    check_eq("cont_start_ready", tx_ready2, 1'b0);
    prev = tx2; rise = 0; n = 0;
    while (!tx_done2 && n <= 400) begin
      @(negedge clk);
      n++;
      if (!prev && tx2) rise = n;
      prev = tx2;
    end
    check_eq("cont_frame_clk", n, NBITS * OS + SBT2);
    check_eq("cont_stop_clk", n - rise, SBT2);
    @(negedge clk);
    check_eq("cont_done_pulse", tx_done2, 1'b0);
    check_eq("cont_ready_back", tx_ready2, 1'b1);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_oversampled.md
# uart_tx_oversampled

Serial transmitter that consumes the one-cycle baud tick from the upstream mod-M tick counter and shifts a parallel byte out as an asynchronous UART frame: one start bit, DBIT data bits LSB first, an optional parity bit, and a stop period. The tick counter free-runs at OS × baud. This block counts ticks, so each bit lasts exactly OS ticks. It sits between the tick counter and the board TX pin, with a simple start/ready/done handshake to the parallel producer.

## Interface
- DBIT, 8: data bits per frame, 5..9.
- OS, 16: ticks per data/start/parity bit; power of two, ≥ 2.
- SB_TICK, 16: ticks in the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2. Must be ≤ 2·OS.
- clk  in  1  system clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- s_tick  in  1  one-cycle pulse from the mod-M tick counter at OS × baud.
- tx_start  in  1  request to send din; sampled only when tx_ready = 1.
- din  in  DBIT  parallel data; captured on the accepting cycle.
- tx_ready  out  1  high in IDLE; request can be accepted.
- tx_done_tick  out  1  one-cycle pulse at the end of the stop period.
- tx  out  1  serial line, registered, idle high.

## Operation
- Registers:
  - state;
  - s_cnt, width $clog2(2·OS);
  - n_cnt, width $clog2(DBIT);
  - b_reg, DBIT-bit shift register;
  - tx_reg, which drives tx.
- Reset values: state = IDLE, tx = 1, tx_ready = 1, tx_done_tick = 0, all counters 0.
- IDLE: tx = 1. When tx_start = 1:
  - load b_reg ← din;
  - clear s_cnt;
  - go to START.
- START: tx = 0. On each s_tick:
  - if s_cnt = OS-1: clear s_cnt, clear n_cnt, go to DATA;
  - otherwise increment s_cnt.
- DATA: tx = b_reg[0]. On s_tick with s_cnt = OS-1:
  - shift b_reg right by one;
  - if n_cnt = DBIT-1, go to PARITY (or STOP when parity is compiled out);
  - otherwise increment n_cnt.
- PARITY: tx = even parity of the captured byte. Leave after OS ticks.
- STOP: tx = 1. On s_tick with s_cnt = SB_TICK-1:
  - assert tx_done_tick for one cycle;
  - go to IDLE.
- Counters advance only on s_tick. Cycles without s_tick hold all state.
- tx_start is ignored outside IDLE. din may change freely after the accepting cycle.

## Timing
- Accept at edge k (IDLE, tx_start = 1): tx falls and tx_ready falls at edge k+1.
- Frame length: (1 + DBIT + P)·OS + SB_TICK ticks, where P = 1 with parity, else 0.
- tx_done_tick and the IDLE transition occur on the same edge. tx_ready is high from that edge on. The earliest next accept is one clk later, giving back-to-back frames with no idle bit.
- s_tick in the same cycle as an accept is not counted; START counting begins at the next tick.
- rst mid-frame aborts the frame: tx = 1 and state = IDLE at the next edge, and no done pulse is issued.
- s_tick is never wider than one cycle. A held-high s_tick counts one tick per cycle, which is legal and used in simulation.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state present. The parity bit is the XOR of din computed at capture (even parity), lasting OS ticks.
- Macro undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Structure
- Shared package uart_pkg holds:
  - typedef enum for the transmitter states (IDLE, START, DATA, PARITY, STOP);
  - default constants UART_DBIT = 8, UART_OS = 16, UART_SB_TICK = 16.
- No sub-module inside this block; parity is one XOR reduction.
- The tick source is the existing mod-M counter, instanced by the parent with max_cnt = clk/(OS·baud); its cout_tick connects to s_tick.

## Test plan
- Reset: hold rst 3 cycles. Required: tx = 1, tx_ready = 1, tx_done_tick = 0 throughout and after release.
- Basic frame (no parity, s_tick every 4 clk): send din = 0xA5. Required:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each level 16 ticks (64 clk);
  - tx_done_tick exactly one cycle, 160 ticks after the accept.
- Parity build: send 0xA5 with the macro defined. Required: parity bit 0, frame 176 ticks. Send 0x07: parity bit 1.
- Back-to-back: assert tx_start = 1 continuously with 0x00 then 0xFF. Required: second start bit begins 1 clk after the first tx_done_tick, and no spurious accept occurs mid-frame.
- Abort: assert rst during bit 3 of a frame. Required: tx = 1 next cycle, no done pulse, next frame 0x3C transmits correctly.
- Continuous tick: s_tick tied high, DBIT = 8, SB_TICK = 32. Required: frame exactly 176 clk, stop level held 32 clk.
